// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state
// encoding, default operand width and a small state-decode helper.
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // The block can take a new request in every state except RUN.
    function automatic logic state_is_ready(input state_e st);
        return (st != ST_RUN);
    endfunction

endpackage

// File: rtl/full_subtractor_str.sv
// One-bit full subtractor built from gate primitives.
//   d    = a ^ b ^ bin
//   bout = (~a & b) | (~(a ^ b) & bin)
module full_subtractor_str (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic axb_s;
    logic na_s;
    logic naxb_s;
    logic gen_s;
    logic prop_s;

    xor u_x1 (axb_s, a, b);
    xor u_x2 (d, axb_s, bin);
    not u_n1 (na_s, a);
    not u_n2 (naxb_s, axb_s);
    and u_a1 (gen_s, na_s, b);
    and u_a2 (prop_s, naxb_s, bin);
    or  u_o1 (bout, gen_s, prop_s);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b (mod 2^WIDTH) one bit per cycle,
// LSB first, using a single full-subtractor cell. Results are presented
// on registered outputs that only change on the done cycle.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;

    logic             fs_d_s;
    logic             fs_bout_s;
    logic [WIDTH-1:0] res_shift_s;
    logic             last_bit_s;

    full_subtractor_str u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (br_q),
        .d    (fs_d_s),
        .bout (fs_bout_s)
    );

    // Result register after shifting in the current difference bit at the MSB.
    assign res_shift_s = {fs_d_s, res_q[WIDTH-1:1]};
    assign last_bit_s  = (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE/DONE accept start, RUN lasts exactly WIDTH cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_bit_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and output next-state: capture, per-bit shift, final result load.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        ready_d  = state_is_ready(state_d);
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d   = a;
                    b_d   = b;
                    res_d = {WIDTH{1'b0}};
                    cnt_d = {CW{1'b0}};
                    br_d  = 1'b0;
                end else begin
                    a_d   = a_q;
                    b_d   = b_q;
                end
            end
            ST_RUN: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                res_d = res_shift_s;
                br_d  = fs_bout_s;
                cnt_d = cnt_q + CNT_ONE;
                if (last_bit_s) begin
                    diff_d   = res_shift_s;
                    borrow_d = fs_bout_s;
                    zero_d   = (res_shift_s == {WIDTH{1'b0}});
                    done_d   = 1'b1;
                end else begin
                    done_d   = 1'b0;
                end
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset leaves zero=1 to match diff=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            res_q    <= {WIDTH{1'b0}};
            cnt_q    <= {CW{1'b0}};
            br_q     <= 1'b0;
            diff_q   <= {WIDTH{1'b0}};
            borrow_q <= 1'b0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign ready  = ready_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vectors plus a
// randomized phase, all checked against a transaction-level reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         ready;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;

    int n_cmp = 0;
    int n_mis = 0;
    int edge_cnt = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .ready  (ready),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    // One operation may be in flight; it completes WIDTH edges after acceptance.
    bit           m_pend    = 1'b0;
    bit           m_take    = 1'b0;
    int           m_edge    = 0;
    int           m_due     = 0;
    logic [W-1:0] m_pdiff   = '0;
    bit           m_pborrow = 1'b0;
    bit           m_pzero   = 1'b1;
    bit           m_done    = 1'b0;
    logic [W-1:0] m_diff    = '0;
    bit           m_borrow  = 1'b0;
    bit           m_zero    = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend   = 1'b0;
            m_done   = 1'b0;
            m_diff   = '0;
            m_borrow = 1'b0;
            m_zero   = 1'b1;
        end else begin
            m_edge++;
            m_take = start && !m_pend;
            m_done = 1'b0;
            if (m_pend && m_edge == m_due) begin
                m_done   = 1'b1;
                m_diff   = m_pdiff;
                m_borrow = m_pborrow;
                m_zero   = m_pzero;
                m_pend   = 1'b0;
            end
            if (m_take) begin
                m_pend    = 1'b1;
                m_due     = m_edge + W;
                m_pdiff   = a - b;
                m_pborrow = (a < b);
                m_pzero   = (a == b);
            end
        end
    end

    // Every cycle: compare all outputs against the model, away from the clock edge.
    always @(negedge clk) begin
        #1;
        chk("done",   32'(done),   32'(m_done));
        chk("ready",  32'(ready),  32'(!m_pend));
        chk("diff",   32'(diff),   32'(m_diff));
        chk("borrow", 32'(borrow), 32'(m_borrow));
        chk("zero",   32'(zero),   32'(m_zero));
    end

    // ---------------- directed helpers ----------------
    task automatic wait_done(output int e);
        e = -1;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) begin
                e = edge_cnt;
                break;
            end
        end
        chk("done_seen", 32'(e >= 0), 32'd1);
    endtask

    task automatic op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W-1:0] ed, input logic eb, input logic ez);
        int acc;
        int e;
        @(negedge clk);
        start = 1'b1; a = av; b = bv;
        acc = edge_cnt + 1;
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom);
        wait_done(e);
        chk({tag, "_lat"},    32'(e - acc), 32'(W));
        chk({tag, "_diff"},   32'(diff),    32'(ed));
        chk({tag, "_borrow"}, 32'(borrow),  32'(eb));
        chk({tag, "_zero"},   32'(zero),    32'(ez));
    endtask

    initial begin
        int acc;
        int e1;
        int e2;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_zero",  32'(zero),  32'd1);
        chk("rst_diff",  32'(diff),  32'd0);
        rst_n = 1'b1;

        // Basic vectors (first start right after reset release)
        op("v35_12", 8'h35, 8'h12, 8'h23, 1'b0, 1'b0);
        op("v00_01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        op("vAA_AA", 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1);
        op("vFF_00", 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);
        op("v80_7F", 8'h80, 8'h7F, 8'h01, 1'b0, 1'b0);

        // Start during RUN is ignored
        @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h01;
        acc = edge_cnt + 1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        wait_done(e1);
        chk("ign_lat",  32'(e1 - acc), 32'(W));
        chk("ign_diff", 32'(diff),     32'h0F);

        // Reset in the middle of RUN
        @(negedge clk);
        start = 1'b1; a = 8'h5C; b = 8'h21;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            #1;
            chk("abort_nodone", 32'(done), 32'd0);
        end
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_zero", 32'(zero), 32'd1);
        op("after_rst", 8'h40, 8'h03, 8'h3D, 1'b0, 1'b0);

        // Start held across DONE: back-to-back operations
        @(negedge clk);
        start = 1'b1; a = 8'h5A; b = 8'hC3;
        wait_done(e1);
        chk("b2b1_diff",   32'(diff),   32'h97);
        chk("b2b1_borrow", 32'(borrow), 32'd1);
        a = 8'h77; b = 8'h77;
        @(negedge clk);
        start = 1'b0;
        wait_done(e2);
        chk("b2b_gap",     32'(e2 - e1), 32'(W + 1));
        chk("b2b2_diff",   32'(diff),    32'h00);
        chk("b2b2_zero",   32'(zero),    32'd1);

        // Randomized phase: random starts, operand churn, rare resets
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 249) != 0);
            start = ($urandom_range(0, 3) == 0);
            a = W'($urandom);
            case ($urandom_range(0, 7))
                0:       b = a;
                1:       b = a + W'(1);
                2:       a = '0;
                default: b = W'($urandom);
            endcase
        end
        @(negedge clk);
        start = 1'b0; rst_n = 1'b1;
        repeat (W + 3) @(negedge clk);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request pulse; sampled only when ready=1.
REQ-005 a  input  WIDTH  minuend; captured on an accepted start.
REQ-006 b  input  WIDTH  subtrahend; captured on an accepted start.
REQ-007 ready  output  1  high when the block can accept start.
REQ-008 done  output  1  one-cycle pulse; diff and flags are valid from this cycle.
REQ-009 diff  output  WIDTH  result a-b modulo 2^WIDTH.
REQ-010 borrow  output  1  final borrow-out; 1 when a<b unsigned.
REQ-011 zero  output  1  1 when diff==0.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE: ready=1; start=1 -> capture a and b into shift registers, clear the borrow flop and bit counter, then go to RUN.
REQ-014 RUN: ready=0; each cycle processes one bit, LSB first:
- d = a0^b0^br
- br_next = (~a0&b0) | (~(a0^b0)&br)
- d shifts into the result register from the MSB end
- both operand registers shift right by one
REQ-015 RUN SHALL last exactly WIDTH cycles, tracked by a counter of width clog2(WIDTH+1), then go to DONE.
REQ-016 DONE: done=1 for exactly that cycle; diff, borrow and zero are updated from the final result; ready=1.
REQ-017 Latency: start accepted at edge N -> done high in the cycle after edge N+WIDTH.
REQ-018 start while ready=0 SHALL be ignored, with no effect on the operation in progress.
REQ-019 start=1 in DONE SHALL be accepted: go directly to RUN with new operands; done still pulses for the old result.
REQ-020 DONE with start=0 -> IDLE.
REQ-021 diff, borrow and zero SHALL hold their last values until the next done; they SHALL NOT change during RUN.
REQ-022 Changes on a and b after capture SHALL have no effect on the result.

Reset
REQ-023 rst_n=0 SHALL immediately force:
- state=IDLE, ready=1, done=0
- diff=0, borrow=0, zero=1
- shift registers, counter and borrow flop cleared
REQ-024 Reset asserted mid-RUN SHALL abort the operation: no done pulse, and no partial result appears on diff.
REQ-025 The first start after rst_n deasserts SHALL be accepted on the first rising edge with ready=1.

Structure
REQ-026 Shared package serial_arith_pkg SHALL hold:
- the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
- default WIDTH constant
REQ-027 The per-bit logic SHALL be one sub-module, full_subtractor_str:
- ports a, b, bin, d, bout
- built structurally from gate primitives
- instantiated once; the FSM, counter and registers stay in serial_subtractor

Verification
REQ-028 WIDTH=8, a=8'h35, b=8'h12, start at edge 0 -> done in the cycle after edge 8; diff=8'h23, borrow=0, zero=0.
REQ-029 a=8'h00, b=8'h01 -> diff=8'hFF, borrow=1, zero=0.
REQ-030 a=8'hAA, b=8'hAA -> diff=8'h00, borrow=0, zero=1.
REQ-031 start with a=8'h10, b=8'h01, then start with a=8'hFF, b=8'hFF at RUN cycle 3 -> ignored; result diff=8'h0F.
REQ-032 start, then rst_n=0 at RUN cycle 4 -> no done pulse; outputs at reset values; the next start completes normally.
REQ-033 start held high across the done cycle with a new operand pair -> two done pulses exactly WIDTH+1 cycles apart, each with the correct result.
